// File: rtl/s_axis_pack.sv
// rtl/s_axis_pack.sv - packs PACK stream beats per word into a small output word FIFO
`timescale 1ns/1ps
module s_axis_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               TVALID,
    output logic                               TREADY,
    input  logic [DATA_WIDTH-1:0]              TDATA,
    input  logic                               TLAST,
    output logic                               data_en,
    input  logic                               data_ready,
    output logic [PACK*DATA_WIDTH-1:0]         data_out,
    output logic                               data_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level
);

    localparam int WW = PACK * DATA_WIDTH;
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    logic [LW-1:0] lane_cnt;
    logic [WW-1:0] lanes;
    logic [WW-1:0] word_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic          accept;
    logic          flush;
    logic          pop;

    // Gating with reset keeps the stream stalled while the block is held in reset.
    assign TREADY     = start && !reset && (count < FULL);
    assign accept     = TVALID && TREADY;
    assign flush      = accept && (TLAST || (lane_cnt == LAST_LANE));
    assign data_en    = (count != '0);
    assign pop        = data_en && data_ready;
    assign fill_level = count;
    assign data_out   = data_en ? mem_data[rd_ptr] : '0;
    assign data_last  = data_en && mem_last[rd_ptr];

    // Lanes above the current one are already zero, so a TLAST flush pushes them as zero.
    always_comb begin
        word_next = lanes;
        for (int i = 0; i < PACK; i++) begin
            if (lane_cnt == LW'(i)) begin
                word_next[i*DATA_WIDTH +: DATA_WIDTH] = TDATA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_cnt <= '0;
            lanes    <= '0;
        end else if (accept) begin
            if (flush) begin
                lane_cnt <= '0;
                lanes    <= '0;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
                lanes    <= word_next;
            end
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({flush, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (flush) begin
            mem_data[wr_ptr] <= word_next;
            mem_last[wr_ptr] <= TLAST;
        end
    end

endmodule

// File: tb/tb_s_axis_pack.sv
// tb/tb_s_axis_pack.sv - self-checking bench for s_axis_pack
`timescale 1ns/1ps
module tb_s_axis_pack;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        TVALID;
    logic        TREADY;
    logic [7:0]  TDATA;
    logic        TLAST;
    logic        data_en;
    logic        data_ready;
    logic [31:0] data_out;
    logic        data_last;
    logic [2:0]  fill_level;

    always #5 clk = ~clk;

    s_axis_pack #(.DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .start(start), .TVALID(TVALID), .TREADY(TREADY),
        .TDATA(TDATA), .TLAST(TLAST), .data_en(data_en), .data_ready(data_ready),
        .data_out(data_out), .data_last(data_last), .fill_level(fill_level)
    );

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    typedef struct {
        int          n;
        logic [31:0] beats;
        logic        last;
        logic [31:0] exp_word;
        logic        exp_last;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    int          stalls = 0;
    int          cyc    = 0;
    exp_t        exp_q[$];
    logic [31:0] cur_word = '0;
    int          cur_n    = 0;
    bit          rand_mode = 1'b0;
    logic        ready_fix = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: beat k of a word lands at byte k; a word closes after PK beats or on TLAST.
    task automatic model_accept(input logic [7:0] d, input logic l);
        cur_word = cur_word | (32'(d) << (8 * cur_n));
        cur_n++;
        if (cur_n == PK || l) begin
            exp_q.push_back('{cur_word, l});
            cur_word = '0;
            cur_n    = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_word = '0;
        cur_n    = 0;
    endtask

    // Offers one beat until accepted; returns at posedge+1 with TVALID dropped.
    task automatic send(input logic [7:0] d, input logic l);
        bit acc = 1'b0;
        int budget = 0;
        while (!acc) begin
            @(negedge clk);
            TVALID = 1'b1;
            TDATA  = d;
            TLAST  = l;
            #1;
            acc = TREADY;
            if (!acc) stalls++;
            @(posedge clk);
            budget++;
            if (!acc && budget > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled expected=accepted");
                break;
            end
        end
        #1;
        TVALID = 1'b0;
        TLAST  = 1'b0;
        if (acc) model_accept(d, l);
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_fill_level", 32'(fill_level), 32'd0);
    endtask

    initial begin
        data_ready = 1'b0;
        forever begin
            @(negedge clk);
            data_ready = rand_mode ? 1'($urandom % 2) : ready_fix;
        end
    end

    // Every cycle: occupancy, empty-output masking, and in-order contents of each pop.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("fill_level", 32'(fill_level), 32'(exp_q.size()));
                chk("data_en", 32'(data_en), 32'(exp_q.size() != 0));
                if (!data_en) begin
                    chk("data_out_empty", data_out, 32'd0);
                    chk("data_last_empty", 32'(data_last), 32'd0);
                end
                if (data_en && data_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected actual=%h expected=none", data_out);
                    end else begin
                        chk("pop_word", data_out, exp_q[0].word);
                        chk("pop_last", 32'(data_last), 32'(exp_q[0].last));
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    vec_t tbl[5];
    int   p0;
    int   c0;

    initial begin
        reset  = 1'b1;
        start  = 1'b1;
        TVALID = 1'b0;
        TDATA  = '0;
        TLAST  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(TREADY), 32'd0);
        chk("rst_data_en", 32'(data_en), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_data_last", 32'(data_last), 32'd0);
        chk("rst_fill_level", 32'(fill_level), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_rst", 32'(TREADY), 32'd1);

        tbl[0] = '{4, 32'h44332211, 1'b1, 32'h44332211, 1'b1};
        tbl[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 1'b1};
        tbl[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 1'b1};
        tbl[3] = '{4, 32'hDDCCBBAA, 1'b0, 32'hDDCCBBAA, 1'b0};
        tbl[4] = '{3, 32'h00030201, 1'b1, 32'h00030201, 1'b1};
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                send(tbl[v].beats[8*k +: 8], tbl[v].last && (k == tbl[v].n - 1));
            end
            chk("vec_data_out", data_out, tbl[v].exp_word);
            chk("vec_data_en", 32'(data_en), 32'd1);
            chk("vec_data_last", 32'(data_last), 32'(tbl[v].exp_last));
            repeat (2) @(posedge clk);
            #1;
        end

        // Backpressure: 20 beats into a stalled consumer, then release.
        ready_fix = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'(i + 1), 1'b0);
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                chk("full_fill_level", 32'(fill_level), 32'd4);
                chk("full_tready", 32'(TREADY), 32'd0);
                ready_fix = 1'b1;
                @(posedge clk);
                #1;
                chk("tready_after_full_pop", 32'(TREADY), 32'd1);
            end
        join
        wait_drain();

        // start dropped mid-word holds the partial lanes.
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            TVALID = 1'b1;
            TDATA  = 8'hEE;
            #1;
            chk("stopped_tready", 32'(TREADY), 32'd0);
        end
        @(posedge clk);
        #1;
        TVALID = 1'b0;
        start  = 1'b1;
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        chk("hold_data_out", data_out, 32'hA4A3A2A1);
        chk("hold_data_last", 32'(data_last), 32'd0);
        wait_drain();

        // Reset with one buffered word and a partial word.
        ready_fix = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) send(8'(8'h71 + i), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        ready_fix = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_fill_level", 32'(fill_level), 32'd0);
        chk("midrst_data_en", 32'(data_en), 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_tready", 32'(TREADY), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        chk("post_rst_word", data_out, 32'h04030201);
        wait_drain();

        // Sustained throughput.
        stalls = 0;
        p0 = pops;
        c0 = cyc;
        for (int i = 0; i < 64; i++) send(8'($urandom), 1'b0);
        chk("stream_cycles", 32'(cyc - c0), 32'd64);
        chk("stream_stalls", 32'(stalls), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_words", 32'(pops - p0), 32'd16);

        // Randomized traffic, consumer stalls and start drops.
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 12 == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                start = 1'b1;
            end
            send(8'($urandom), ($urandom % 5) == 0);
        end
        send(8'h99, 1'b1);
        rand_mode = 1'b0;
        ready_fix = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_axis_pack.md
S_AXIS_PACK -- requirements
Module: s_axis_pack

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the width of one input beat in bits.
REQ-002 Parameter PACK, default 4, shall set the input beats per output word; legal values are 1 or more.
REQ-003 Parameter FIFO_DEPTH, default 4, shall set the output word FIFO depth; legal values are powers of 2, 2 or more.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  enables stream acceptance when high.
REQ-007 TVALID  input  1  AXI-Stream beat valid.
REQ-008 TREADY  output  1  AXI-Stream beat ready.
REQ-009 TDATA  input  DATA_WIDTH  AXI-Stream beat data.
REQ-010 TLAST  input  1  AXI-Stream end of packet.
REQ-011 data_en  output  1  a packed word is valid on data_out.
REQ-012 data_ready  input  1  the downstream consumer accepts the word.
REQ-013 data_out  output  PACK*DATA_WIDTH  the packed word.
REQ-014 data_last  output  1  the word on data_out closes a packet.
REQ-015 fill_level  output  clog2(FIFO_DEPTH+1)  number of words held in the FIFO.

Function
REQ-016 A beat shall be accepted only in a cycle with TVALID=1 and TREADY=1.
REQ-017 TREADY shall equal start AND (fill_level < FIFO_DEPTH); it is combinational and does not depend on TVALID.
REQ-018 Accepted beats shall fill lanes in order: the first beat goes to lane 0 (bits DATA_WIDTH-1:0), then lane 1, and so on; a lane counter tracks the next lane.
REQ-019 On acceptance of beat PACK, or of any beat with TLAST=1, the block shall push the completed word plus a last flag (equal to TLAST) into the FIFO in the same edge, clear all lane registers, and return the lane counter to 0.
REQ-020 On a TLAST flush, lanes above the final beat shall be zero in the pushed word.
REQ-021 data_en shall equal (fill_level != 0); data_out and data_last shall show the FIFO head, and shall be 0 when the FIFO is empty.
REQ-022 A word shall pop on a clock edge where data_en=1 and data_ready=1; data_out shall not change while data_en=1 and data_ready=0.
REQ-023 Latency: the word shall appear on data_out the cycle after its final beat is accepted, provided the FIFO was empty.
REQ-024 A push and a pop in the same cycle shall leave fill_level unchanged and keep word order.
REQ-025 When the FIFO is full, TREADY shall be 0 and no beat shall be lost; a pop in a full cycle shall raise TREADY in the next cycle.
REQ-026 If start deasserts mid-word, the partial lanes and the lane counter shall be held, and accumulation shall resume when start reasserts.
REQ-027 If PACK=1, every accepted beat shall produce one word.
REQ-028 Read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-029 While reset=1, fill_level, pointers, the lane counter and the lane registers shall be 0; data_en, data_out and data_last shall be 0; TREADY shall be 0.
REQ-030 A reset asserted mid-word or mid-packet shall discard all partial and buffered data; the first accepted beat after release goes to lane 0.

Verification
REQ-031 Defaults, start=1, data_ready=1, beats 0x11,0x22,0x33,0x44 with TLAST on the 4th -> one cycle later data_out=0x44332211, data_en=1, data_last=1.
REQ-032 Beats 0xAA,0xBB with TLAST on 0xBB -> data_out=0x0000BBAA, data_last=1, then the next packet starts at lane 0.
REQ-033 data_ready=0, 20 beats streamed with no TLAST -> 4 words stored, fill_level=4, TREADY=0; release data_ready -> the words emerge in order, all beats are intact, and none is dropped.
REQ-034 start dropped after 2 beats for 5 cycles, then 2 more beats -> a single word containing all 4 beats in order.
REQ-035 reset pulsed after 3 beats, then beats 0x01..0x04 -> data_out=0x04030201, with no stale lanes.
REQ-036 Continuous TVALID and data_ready for 64 beats -> sustained 1 beat per cycle, TREADY held at 1, and 16 words emitted in order.
